// File: rtl/ysyx_220066_mem_arb.sv
// Two-requester (IF / LSU) arbiter serialising onto a single valid/ready memory
// channel, one outstanding transaction, with starvation guard and response timeout.
module ysyx_220066_mem_arb #(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_addr,
  input  logic        ls_wen,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_resp_valid,
  input  logic        ls_resp_ready,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,
  input  logic        mem_resp_err,
  output logic        busy
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mreq_t;

  state_t        state, state_nx;
  logic          owner;
  mreq_t         req_q, req_sel;
  logic [SW-1:0] starve;
  logic [TW-1:0] tmo;
  logic          drop;
  logic [63:0]   if_rdata_q, ls_rdata_q;
  logic          if_err_q, ls_err_q;

  logic contested, starved, gnt_ls, gnt_if, accept;
  logic mem_hs, resp_ok, tmo_hit;
  logic cap, tmo_fire, set_drop;
  logic addr_lo_unused;

  // Memory is doubleword-addressed; sub-doubleword offsets live in the mask.
  assign addr_lo_unused = ^{if_addr[2:0], ls_addr[2:0]};

  assign contested = if_req_valid & ls_req_valid;
  assign starved   = (starve == STARVE_MAX);
  assign gnt_ls    = ls_req_valid & ~(if_req_valid & starved);
  assign gnt_if    = if_req_valid & ~gnt_ls;
  assign accept    = rst & (state == IDLE) & (gnt_ls | gnt_if);

  assign if_req_ready = rst & (state == IDLE) & gnt_if;
  assign ls_req_ready = rst & (state == IDLE) & gnt_ls;

  // While a late response is still owed to an aborted transaction, hold off issue.
  assign mem_req_valid = (state == REQ) & ~drop;
  assign mem_hs        = mem_req_valid & mem_req_ready;
  assign resp_ok       = mem_resp_valid & ~drop;
  assign tmo_hit       = (tmo == TMO_LAST);

  always_comb begin
    req_sel = '0;
    if (gnt_ls) begin
      req_sel.addr  = {ls_addr[63:3], 3'b000};
      req_sel.wen   = ls_wen;
      req_sel.wdata = ls_wdata;
      req_sel.wmask = ls_wen ? ls_wmask : 8'h00;
    end else begin
      req_sel.addr  = {if_addr[63:3], 3'b000};
    end
  end

  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    tmo_fire = 1'b0;
    set_drop = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = REQ;
      REQ: begin
        if (mem_hs && resp_ok) begin
          state_nx = RESP;
          cap      = 1'b1;
        end else if (tmo_hit) begin
          state_nx = RESP;
          tmo_fire = 1'b1;
          set_drop = mem_hs;
        end else if (mem_hs) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (resp_ok) begin
          state_nx = RESP;
          cap      = 1'b1;
        end else if (tmo_hit) begin
          state_nx = RESP;
          tmo_fire = 1'b1;
          set_drop = 1'b1;
        end
      end
      RESP: if (owner ? ls_resp_ready : if_resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      req_q      <= '0;
      starve     <= '0;
      tmo        <= '0;
      drop       <= 1'b0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      ls_rdata_q <= '0;
      ls_err_q   <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        owner <= gnt_ls;
        req_q <= req_sel;
        tmo   <= '0;
        if (gnt_if)
          starve <= '0;
        else if (contested && !starved)
          starve <= starve + 1'b1;
      end else if (state == REQ || state == WAIT) begin
        tmo <= tmo + 1'b1;
      end

      if (set_drop)
        drop <= 1'b1;
      else if (drop && mem_resp_valid)
        drop <= 1'b0;

      if (cap || tmo_fire) begin
        if (owner) begin
          ls_rdata_q <= tmo_fire ? 64'h0 : mem_resp_rdata;
          ls_err_q   <= tmo_fire ? 1'b1 : mem_resp_err;
        end else begin
          if_rdata_q <= tmo_fire ? 64'h0 : mem_resp_rdata;
          if_err_q   <= tmo_fire ? 1'b1 : mem_resp_err;
        end
      end
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wen   = req_q.wen;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;

  assign if_resp_valid = (state == RESP) & ~owner;
  assign ls_resp_valid = (state == RESP) & owner;
  assign if_rdata      = if_rdata_q;
  assign if_err        = if_err_q;
  assign ls_rdata      = ls_rdata_q;
  assign ls_err        = ls_err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ysyx_220066_mem_arb.sv
// Directed bench for ysyx_220066_mem_arb: latency, arbitration fairness,
// write path, timeout/drop, backpressure and mid-transaction reset.
module tb_ysyx_220066_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_err;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_ready, ls_err;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err, busy;
  logic [63:0] mem_addr, mem_wdata, mem_resp_rdata;
  logic [7:0]  mem_wmask;

  int tests  = 0;
  int failed = 0;

  localparam logic [63:0] IF_A  = 64'h0000_0000_8000_1004;
  localparam logic [63:0] IF_AL = 64'h0000_0000_8000_1000;
  localparam logic [63:0] LS_A  = 64'h0000_0000_8000_2017;
  localparam logic [63:0] LS_AL = 64'h0000_0000_8000_2010;

  bit grant_a [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  bit grant_b [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  ysyx_220066_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_err(mem_resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle with both requesters valid; memory answers in the REQ cycle.
  task automatic arb_txn(input bit exp_ls, input logic [63:0] rd);
    #1;
    chk("grant_ls", ls_req_ready, exp_ls);
    chk("grant_if", if_req_ready, !exp_ls);
    cyc();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = rd;
    #1;
    chk("arb_mem_valid", mem_req_valid, 1'b1);
    chk("arb_mem_addr", mem_addr, exp_ls ? LS_AL : IF_AL);
    cyc();
    mem_resp_valid = 1'b0;
    #1;
    chk("arb_ls_resp_valid", ls_resp_valid, exp_ls);
    chk("arb_if_resp_valid", if_resp_valid, !exp_ls);
    chk("arb_rdata", exp_ls ? ls_rdata : if_rdata, rd);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if_req_valid = 0; if_addr = 0; if_resp_ready = 1;
    ls_req_valid = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_wmask = 0; ls_resp_ready = 1;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; mem_resp_err = 0;

    // Reset state; readies stay low under reset even with valid requests
    cyc(); cyc();
    if_req_valid = 1; ls_req_valid = 1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_if_ready", if_req_ready, 1'b0);
    chk("rst_ls_ready", ls_req_ready, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_if_resp", if_resp_valid, 1'b0);
    chk("rst_ls_resp", ls_resp_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wmask", mem_wmask, 8'h00);
    chk("rst_if_rdata", if_rdata, 64'h0);
    chk("rst_errs", {if_err, ls_err}, 2'b00);
    if_req_valid = 0; ls_req_valid = 0;
    cyc();
    rst = 1;
    cyc();

    // IF-only read, same-cycle memory response
    if_req_valid = 1; if_addr = 64'h8000_0004; mem_req_ready = 1;
    #1;
    chk("t1_if_ready", if_req_ready, 1'b1);
    chk("t1_ls_ready", ls_req_ready, 1'b0);
    cyc();
    if_req_valid = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h1111_2222_3333_4444;
    #1;
    chk("t1_mem_valid", mem_req_valid, 1'b1);
    chk("t1_mem_addr", mem_addr, 64'h8000_0000);
    chk("t1_mem_wmask", mem_wmask, 8'h00);
    chk("t1_mem_wen", mem_wen, 1'b0);
    cyc();
    mem_resp_valid = 0;
    #1;
    chk("t1_if_resp", if_resp_valid, 1'b1);
    chk("t1_if_rdata", if_rdata, 64'h1111_2222_3333_4444);
    chk("t1_if_err", if_err, 1'b0);
    chk("t1_ls_resp", ls_resp_valid, 1'b0);
    cyc();
    #1;
    chk("t1_idle", busy, 1'b0);
    chk("t1_if_resp_done", if_resp_valid, 1'b0);

    // LSU write: byte lane 3 of doubleword 0x8000_0010
    ls_req_valid = 1; ls_addr = 64'h8000_0013; ls_wen = 1; ls_wdata = 64'hAB00_0000; ls_wmask = 8'h08;
    #1;
    chk("t3_ls_ready", ls_req_ready, 1'b1);
    chk("t3_if_ready", if_req_ready, 1'b0);
    cyc();
    ls_req_valid = 0; ls_wen = 0; ls_wdata = 0; ls_wmask = 0;
    #1;
    chk("t3_mem_valid", mem_req_valid, 1'b1);
    chk("t3_mem_addr", mem_addr, 64'h8000_0010);
    chk("t3_mem_wen", mem_wen, 1'b1);
    chk("t3_mem_wmask", mem_wmask, 8'h08);
    chk("t3_mem_wdata", mem_wdata, 64'hAB00_0000);
    cyc();
    mem_resp_valid = 1; mem_resp_rdata = 64'h5A5A; mem_resp_err = 0;
    #1;
    chk("t3_wait_valid", mem_req_valid, 1'b0);
    chk("t3_wait_busy", busy, 1'b1);
    chk("t3_wait_resp", ls_resp_valid, 1'b0);
    cyc();
    mem_resp_valid = 0;
    #1;
    chk("t3_ls_resp", ls_resp_valid, 1'b1);
    chk("t3_ls_err", ls_err, 1'b0);
    chk("t3_if_resp", if_resp_valid, 1'b0);
    cyc();
    #1;
    chk("t3_idle", busy, 1'b0);

    // Contested stream: IF forced through after four LSU wins
    if_req_valid = 1; if_addr = IF_A; ls_req_valid = 1; ls_addr = LS_A; ls_wen = 0;
    for (int i = 0; i < 8; i++) arb_txn(grant_a[i], 64'hC0DE_0000 + 64'(i));

    // Reset in WAIT (starve counter is 3 here, 4 after this grant)
    #1;
    chk("t6_ls_ready", ls_req_ready, 1'b1);
    cyc();
    if_req_valid = 0; ls_req_valid = 0;
    #1;
    chk("t6_mem_valid", mem_req_valid, 1'b1);
    cyc();
    rst = 0;
    #1;
    chk("t6_wait_busy", busy, 1'b1);
    cyc();
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_mem_valid", mem_req_valid, 1'b0);
    chk("t6_rst_ls_resp", ls_resp_valid, 1'b0);
    chk("t6_rst_if_resp", if_resp_valid, 1'b0);
    chk("t6_rst_mem_addr", mem_addr, 64'h0);
    rst = 1; ls_req_valid = 1; ls_addr = LS_A;
    #1;
    chk("t6_ls_ready", ls_req_ready, 1'b1);
    cyc();
    ls_req_valid = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h7777;
    #1;
    chk("t6_mem_valid2", mem_req_valid, 1'b1);
    cyc();
    mem_resp_valid = 0;
    #1;
    chk("t6_ls_resp", ls_resp_valid, 1'b1);
    chk("t6_ls_rdata", ls_rdata, 64'h7777);
    cyc();
    if_req_valid = 1; ls_req_valid = 1;
    for (int i = 0; i < 5; i++) arb_txn(grant_b[i], 64'hBEEF_0000 + 64'(i));

    // Timeout: memory accepts but never answers
    if_req_valid = 0; ls_req_valid = 1; ls_addr = 64'h8000_3008;
    #1;
    chk("t4_ls_ready", ls_req_ready, 1'b1);
    cyc();
    ls_req_valid = 0;
    #1;
    chk("t4_mem_valid", mem_req_valid, 1'b1);
    repeat (254) cyc();
    #1;
    chk("t4_pre_resp", ls_resp_valid, 1'b0);
    chk("t4_pre_busy", busy, 1'b1);
    cyc();
    #1;
    chk("t4_resp", ls_resp_valid, 1'b1);
    chk("t4_err", ls_err, 1'b1);
    chk("t4_rdata", ls_rdata, 64'h0);
    cyc();
    if_req_valid = 1; if_addr = 64'h8000_4000;
    #1;
    chk("t4_if_ready", if_req_ready, 1'b1);
    cyc();
    if_req_valid = 0;
    #1;
    chk("t4_stall", mem_req_valid, 1'b0);
    chk("t4_stall_busy", busy, 1'b1);
    repeat (8) cyc();
    mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD; mem_resp_err = 1;
    #1;
    chk("t4_late_stall", mem_req_valid, 1'b0);
    cyc();
    mem_resp_valid = 0; mem_resp_err = 0;
    #1;
    chk("t4_late_dropped", if_resp_valid, 1'b0);
    chk("t4_issue", mem_req_valid, 1'b1);
    chk("t4_issue_addr", mem_addr, 64'h8000_4000);
    mem_resp_valid = 1; mem_resp_rdata = 64'h600D;
    cyc();
    mem_resp_valid = 0;
    #1;
    chk("t4_if_resp", if_resp_valid, 1'b1);
    chk("t4_if_rdata", if_rdata, 64'h600D);
    chk("t4_if_err", if_err, 1'b0);
    chk("t4_ls_resp", ls_resp_valid, 1'b0);
    cyc();
    #1;
    chk("t4_idle", busy, 1'b0);

    // Backpressure on both the memory request and the IF response
    if_req_valid = 1; if_addr = 64'h1000_000C; mem_req_ready = 0;
    #1;
    chk("t5_if_ready", if_req_ready, 1'b1);
    cyc();
    if_req_valid = 0; if_addr = 0;
    #1;
    chk("t5_mem_valid", mem_req_valid, 1'b1);
    chk("t5_mem_addr", mem_addr, 64'h1000_0008);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk("t5_hold_valid", mem_req_valid, 1'b1);
      chk("t5_hold_addr", mem_addr, 64'h1000_0008);
      chk("t5_hold_wen", {mem_wen, mem_wmask}, 9'h000);
    end
    cyc();
    mem_req_ready = 1;
    #1;
    chk("t5_hs_valid", mem_req_valid, 1'b1);
    cyc();
    mem_resp_valid = 1; mem_resp_rdata = 64'hFEED_F00D_0BAD_CAFE; if_resp_ready = 0;
    #1;
    chk("t5_wait", mem_req_valid, 1'b0);
    cyc();
    mem_resp_valid = 0; mem_resp_rdata = 0;
    #1;
    chk("t5_resp", if_resp_valid, 1'b1);
    chk("t5_rdata", if_rdata, 64'hFEED_F00D_0BAD_CAFE);
    for (int k = 0; k < 2; k++) begin
      cyc();
      #1;
      chk("t5_resp_hold", if_resp_valid, 1'b1);
      chk("t5_rdata_hold", if_rdata, 64'hFEED_F00D_0BAD_CAFE);
    end
    cyc();
    if_resp_ready = 1;
    #1;
    chk("t5_resp_last", if_resp_valid, 1'b1);
    chk("t5_busy_last", busy, 1'b1);
    cyc();
    #1;
    chk("t5_idle", busy, 1'b0);
    chk("t5_resp_done", if_resp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_mem_arb.md
Name: ysyx_220066_mem_arb

Overview:
Two-requester arbiter for the core's single memory port.
- Requesters: the instruction-fetch unit (read-only) and the load/store unit (read/write with byte mask).
- Requests are serialised onto one valid/ready memory channel, one outstanding transaction at a time.
- Each response is routed back to the owner; no-response timeout is reported as an error.
- Sits between the CPU pipeline and the memory/bus adapter, replacing direct combinational memory access.

Parameters:
MAX_WAIT, 4, consecutive contested cycles LSU may win before IF is forced to win
TIMEOUT, 255, cycles in REQ+WAIT before transaction is aborted with error (fits 8-bit counter)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
if_req_valid  in  1  IF request
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  64  IF address
if_resp_valid  out  1  IF response valid
if_resp_ready  in  1  IF consumes response
if_rdata  out  64  IF read data (aligned doubleword)
if_err  out  1  IF response error
ls_req_valid  in  1  LSU request
ls_req_ready  out  1  LSU request accepted
ls_addr  in  64  LSU address
ls_wen  in  1  1=write, 0=read
ls_wdata  in  64  write data, already lane-aligned
ls_wmask  in  8  byte write mask
ls_resp_valid  out  1  LSU response valid
ls_resp_ready  in  1  LSU consumes response
ls_rdata  out  64  LSU read data (aligned doubleword)
ls_err  out  1  LSU response error
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  64  {addr[63:3],3'b000}
mem_wen  out  1  write enable
mem_wdata  out  64  write data
mem_wmask  out  8  byte mask (8'h00 for reads)
mem_resp_valid  in  1  memory response, single-cycle pulse
mem_resp_rdata  in  64  memory read data
mem_resp_err  in  1  memory error
busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; all valid/ready/err outputs 0; rdata, mem_* fields 0; starve counter, timeout counter, drop flag 0. Applies mid-transaction; any in-flight transaction is abandoned without a response.
- States: IDLE, REQ, WAIT, RESP. Owner register: 0=IF, 1=LSU.
- IDLE: select one requester combinationally; assert only that requester's req_ready.
  - Only LS valid -> LSU. Only IF valid -> IF.
  - Both valid -> LSU, unless starve==MAX_WAIT, in which case IF.
  - On handshake: latch addr/wen/wdata/wmask (IF: wen=0, mask=0) and owner; go to REQ.
- Starve counter:
  - Increments when both requesters are valid in IDLE and LSU wins.
  - Clears whenever IF is granted.
  - Saturates at MAX_WAIT.
- REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready; then go to WAIT.
- WAIT: on mem_resp_valid (with drop=0), capture rdata/err into the owner's response registers and go to RESP.
- Same-cycle response allowed: mem_resp_valid in the same cycle as the mem_req handshake is captured (REQ -> RESP directly).
- Timeout counter:
  - Clears on entry to REQ; counts every cycle in REQ or WAIT.
  - At ==TIMEOUT: go to RESP with err=1, rdata=0, mem_req_valid deasserted.
  - If the timeout fires in WAIT, set drop=1. The next mem_resp_valid is discarded and clears drop. mem_req_valid is not issued while drop=1 (REQ stalls).
- RESP: owner's resp_valid=1, rdata/err stable until resp_ready; then go to IDLE. The non-owner's resp_valid is always 0.
- Latency: request accepted in cycle N -> mem_req_valid in N+1. With mem ready and response in N+1, resp_valid is in N+2. Minimum turnaround is 3 cycles per transaction; a new request is accepted no earlier than the cycle after the response handshake.
- Writes return a response; rdata is whatever memory returns and is ignored by the LSU.
- ls_wen=1 with ls_wmask=0 is issued unchanged.
- Requesters hold valid and fields until ready. The arbiter relies on this only in IDLE; fields are latched.

Test Plan:
- IF only, addr 0x8000_0004, mem ready immediately, rdata 0x1111_2222_3333_4444 next cycle -> mem_addr 0x8000_0000, mem_wmask 0x00; if_resp_valid 2 cycles after accept, if_rdata as given; ls_resp_valid stays 0.
- Both valid continuously, LSU read stream, MAX_WAIT=4 -> grant sequence LS,LS,LS,LS,IF,LS,…; IF never waits more than 5 grants.
- LSU write addr 0x8000_0013, wdata 0xAB<<24, wmask 0x08 -> mem_addr 0x8000_0010, mem_wen=1, mem_wmask 0x08; ls_resp_valid after mem response, ls_err=0.
- Memory never responds, TIMEOUT=255 -> ls_resp_valid with ls_err=1, rdata=0 at 255 cycles after REQ entry. A late mem_resp_valid 10 cycles later is dropped. The next IF transaction completes correctly.
- Backpressure: mem_req_ready low 5 cycles, then if_resp_ready low 3 cycles -> mem_* fields stable across the stall; if_rdata stable while held; returns to IDLE one cycle after the resp handshake.
- Assert rst=0 in WAIT -> next cycle busy=0, all valids 0. Deassert rst, then issue an LSU read -> completes normally, starve counter restarted from 0.
